mips_cpu_bus_arbiter: RTL

Two-port to single-port bus arbiter placed between the CPU core's instruction-fetch port and data (load/store) port and the single Avalon-style memory bus leaving `mips_cpu_bus`. Each requester sees a private waitrequest-handshaked port. The arbiter serialises their transfers onto the one bus, holding each transfer until the memory drops `waitrequest`. All bus-side outputs are registered, so no combinational path runs from a requester to the memory.

---
 rtl/mips_cpu_bus_arbiter_if.sv | 39 +++
 rtl/mips_cpu_bus_arbiter.sv | 80 ++++++++
 2 files changed

// File: rtl/mips_cpu_bus_arbiter_if.sv
// mips_cpu_bus_arbiter_if: requester ports (fetch, data) plus the shared Avalon-style memory bus.
// master = arbiter view, slave = requesters/memory view.
interface mips_cpu_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   i_address;
    logic                i_read;
    logic                i_waitrequest;
    logic [DATA_W-1:0]   i_readdata;
    logic [ADDR_W-1:0]   d_address;
    logic                d_read;
    logic                d_write;
    logic [DATA_W-1:0]   d_writedata;
    logic [DATA_W/8-1:0] d_byteenable;
    logic                d_waitrequest;
    logic [DATA_W-1:0]   d_readdata;
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        input  i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
               waitrequest, readdata,
        output i_waitrequest, i_readdata, d_waitrequest, d_readdata,
               address, read, write, writedata, byteenable
    );

    modport slave (
        output i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
               waitrequest, readdata,
        input  i_waitrequest, i_readdata, d_waitrequest, d_readdata,
               address, read, write, writedata, byteenable
    );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: serialises fetch and data requests onto one registered memory bus.
// Define MIPS_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority D > I.
module mips_cpu_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    mips_cpu_bus_arbiter_if.master   bus
);
    localparam int BE_W = DATA_W / 8;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state, w_next;
    logic              r_owner, r_last;
    logic [ADDR_W-1:0] r_address;
    logic              r_read, r_write;
    logic [DATA_W-1:0] r_writedata, r_i_readdata, r_d_readdata;
    logic [BE_W-1:0]   r_byteenable;
    logic              w_i_act, w_d_act, w_grant_d;

    // owner / last_grant encoding: 1 = data port, 0 = fetch port
    always_comb begin
        w_i_act   = bus.i_read;
        w_d_act   = bus.d_read | bus.d_write;
        w_grant_d = w_d_act && !(RR && w_i_act && r_last);
        w_next    = (r_state == IDLE) ? ((w_i_act | w_d_act) ? BUSY : IDLE) :
                    (r_state == BUSY) ? (bus.waitrequest ? BUSY : DONE) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b0;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_i_readdata <= '0;
            r_d_readdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (w_i_act | w_d_act)) begin
                r_owner      <= w_grant_d;
                r_address    <= w_grant_d ? bus.d_address : bus.i_address;
                r_read       <= !w_grant_d || !bus.d_write;
                r_write      <= w_grant_d && bus.d_write;
                r_writedata  <= w_grant_d ? bus.d_writedata : '0;
                r_byteenable <= w_grant_d ? bus.d_byteenable : '1;
            end
            if (r_state == BUSY && !bus.waitrequest) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                r_last  <= r_owner;
                if (r_owner)
                    r_d_readdata <= r_write ? '0 : bus.readdata;
                else
                    r_i_readdata <= bus.readdata;
            end
        end
    end

    assign bus.address       = r_address;
    assign bus.read          = r_read;
    assign bus.write         = r_write;
    assign bus.writedata     = r_writedata;
    assign bus.byteenable    = r_byteenable;
    assign bus.i_readdata    = r_i_readdata;
    assign bus.d_readdata    = r_d_readdata;
    assign bus.i_waitrequest = !(r_state == DONE && !r_owner);
    assign bus.d_waitrequest = !(r_state == DONE && r_owner);
endmodule
